ysyx_040750_icache_refill: RTL

AXI4 read-burst master that refills one cache line on an I-cache miss. It accepts a line-fill request, issues a single INCR burst on its AXI read channel, and assembles the returned beats into a line buffer. It hands the completed line back to the cache. The AXI side connects directly to one requester channel (ch0 or ch1) of the two-channel read crossbar.

---
 rtl/ysyx_040750_axi_pkg.sv | 14 +
 rtl/ysyx_040750_line_buf.sv | 26 ++
 rtl/ysyx_040750_icache_refill.sv | 119 +++++++++++
 3 files changed

// File: rtl/ysyx_040750_axi_pkg.sv
// AXI constants and refill FSM encodings shared by the crossbar and its read masters.
package ysyx_040750_axi_pkg;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    AR   = 4'b0010,
    RD   = 4'b0100,
    DONE = 4'b1000
  } refill_state_t;

endpackage

// File: rtl/ysyx_040750_line_buf.sv
// Cache-line assembly buffer: one 64-bit slot per beat, indexed write, flat read.
module ysyx_040750_line_buf #(
  parameter int LINE_BEATS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [63:0]                wr_data,
  output logic [64*LINE_BEATS-1:0]   rd_data
);

  logic [LINE_BEATS-1:0][63:0] mem;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/ysyx_040750_icache_refill.sv
// I-cache line refill: one INCR read burst per miss, beats assembled into a line buffer.
// Fill handed back as a one-cycle pulse; fill_err flags a burst whose length was not LINE_BEATS.
module ysyx_040750_icache_refill
  import ysyx_040750_axi_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int OFS_W      = 5
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_req_valid,
  input  logic [31:0]               I_req_addr,
  output logic                      O_req_ready,
  output logic                      O_fill_valid,
  output logic [31:0]               O_fill_addr,
  output logic [64*LINE_BEATS-1:0]  O_fill_data,
  output logic                      O_fill_err,
  output logic [31:0]               O_araddr,
  output logic                      O_arvalid,
  input  logic                      I_arready,
  output logic [7:0]                O_arlen,
  output logic [2:0]                O_arsize,
  output logic [1:0]                O_arburst,
  input  logic [63:0]               I_rdata,
  input  logic                      I_rvalid,
  input  logic                      I_rlast,
  output logic                      O_rready
);

  localparam int IDX_W = $clog2(LINE_BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LINE_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_BEATS - 1);
  localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFS_W) - 32'd1);

  refill_state_t    state_q, state_d;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             beat;
  logic             buf_we;

  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Outputs decode from state only, so arvalid never follows arready combinationally.
  always_comb begin
    state_d      = state_q;
    O_req_ready  = 1'b0;
    O_arvalid    = 1'b0;
    O_araddr     = '0;
    O_rready     = 1'b0;
    O_fill_valid = 1'b0;
    O_fill_err   = 1'b0;
    case (state_q)
      IDLE: begin
        O_req_ready = 1'b1;
        if (I_req_valid) state_d = AR;
      end
      AR: begin
        O_arvalid = 1'b1;
        O_araddr  = addr_q;
        if (I_arready) state_d = RD;
      end
      RD: begin
        O_rready = 1'b1;
        if (I_rvalid && I_rlast) state_d = DONE;
      end
      DONE: begin
        O_fill_valid = 1'b1;
        O_fill_err   = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat   = O_rready && I_rvalid;
  assign buf_we = beat && (cnt_q != CNT_FULL);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (O_req_ready && I_req_valid) begin
        addr_q <= I_req_addr & LINE_MASK;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
      if (beat) begin
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
        // Overlong bursts are flagged on the first extra beat; short ones on rlast.
        if ((cnt_q == CNT_FULL) || (I_rlast && (cnt_q != CNT_LAST))) err_q <= 1'b1;
      end
    end
  end

  ysyx_040750_line_buf #(
    .LINE_BEATS (LINE_BEATS),
    .IDX_W      (IDX_W)
  ) u_line_buf (
    .clk     (I_clk),
    .clr     (I_rst),
    .wr_en   (buf_we),
    .wr_idx  (cnt_q[IDX_W-1:0]),
    .wr_data (I_rdata),
    .rd_data (O_fill_data)
  );

  assign O_fill_addr = addr_q;
  assign O_arlen     = 8'(LINE_BEATS - 1);
  assign O_arsize    = AXI_SIZE_8B;
  assign O_arburst   = AXI_BURST_INCR;

endmodule
